// File: rtl/spi_txn_arbiter.sv
// Two-requester arbiter in front of an SPI byte engine. Each grant runs one multi-byte
// transaction under a single chip-select assertion with setup, hold and idle spacing.
module spi_txn_arbiter #(
  parameter int unsigned CS_SETUP_CLKS = 4,
  parameter int unsigned CS_HOLD_CLKS  = 4,
  parameter int unsigned CS_IDLE_CLKS  = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,

  input  logic             i_A_Req,
  input  logic [CNT_W-1:0] i_A_Count,
  input  logic [7:0]       i_A_TX_Byte,
  output logic             o_A_Grant,
  output logic             o_A_TX_Taken,
  output logic             o_A_RX_DV,
  output logic             o_A_Done,

  input  logic             i_B_Req,
  input  logic [CNT_W-1:0] i_B_Count,
  input  logic [7:0]       i_B_TX_Byte,
  output logic             o_B_Grant,
  output logic             o_B_TX_Taken,
  output logic             o_B_RX_DV,
  output logic             o_B_Done,

  output logic [7:0]       o_RX_Byte,

  output logic [7:0]       o_SPI_TX_Byte,
  output logic             o_SPI_TX_DV,
  input  logic             i_SPI_TX_Ready,
  input  logic             i_SPI_RX_DV,
  input  logic [7:0]       i_SPI_RX_Byte,
  output logic             o_SPI_CS_n
);

  localparam logic [7:0] SetupInit = 8'(CS_SETUP_CLKS);
  localparam logic [7:0] HoldInit  = 8'(CS_HOLD_CLKS);
  localparam logic [7:0] IdleInit  = 8'(CS_IDLE_CLKS);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StSend,
    StWaitRx,
    StHold,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             rr_b_q, rr_b_d;  // 1: B wins a tie (A was served last)
  logic             grant_a_q, grant_a_d;
  logic             grant_b_q, grant_b_d;
  logic             cs_n_q, cs_n_d;
  logic             tx_dv_q, tx_dv_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             a_taken_q, a_taken_d;
  logic             b_taken_q, b_taken_d;
  logic             a_rx_dv_q, a_rx_dv_d;
  logic             b_rx_dv_q, b_rx_dv_d;
  logic             a_done_q, a_done_d;
  logic             b_done_q, b_done_d;

  logic             timer_last;
  logic [7:0]       timer_dec;

  assign timer_last = (timer_q <= 8'd1);
  assign timer_dec  = (timer_q == 8'd0) ? 8'd0 : timer_q - 8'd1;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    rr_b_d      = rr_b_q;
    grant_a_d   = grant_a_q;
    grant_b_d   = grant_b_q;
    cs_n_d      = cs_n_q;
    tx_byte_d   = tx_byte_q;
    rx_byte_d   = rx_byte_q;
    tx_dv_d     = 1'b0;
    a_taken_d   = 1'b0;
    b_taken_d   = 1'b0;
    a_rx_dv_d   = 1'b0;
    b_rx_dv_d   = 1'b0;
    a_done_d    = 1'b0;
    b_done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_A_Req && (!i_B_Req || !rr_b_q)) begin
          grant_a_d   = 1'b1;
          cs_n_d      = 1'b0;
          remaining_d = i_A_Count;
          timer_d     = SetupInit;
          rr_b_d      = 1'b1;
          state_d     = StSetup;
        end else if (i_B_Req) begin
          grant_b_d   = 1'b1;
          cs_n_d      = 1'b0;
          remaining_d = i_B_Count;
          timer_d     = SetupInit;
          rr_b_d      = 1'b0;
          state_d     = StSetup;
        end
      end

      StSetup: begin
        if (timer_last) begin
          if (remaining_q != '0) begin
            timer_d = 8'd0;
            state_d = StSend;
          end else begin
            timer_d = HoldInit;
            state_d = StHold;
          end
        end else begin
          timer_d = timer_dec;
        end
      end

      StSend: begin
        if (i_SPI_TX_Ready) begin
          tx_byte_d = grant_b_q ? i_B_TX_Byte : i_A_TX_Byte;
          tx_dv_d   = 1'b1;
          a_taken_d = grant_a_q;
          b_taken_d = grant_b_q;
          state_d   = StWaitRx;
        end
      end

      StWaitRx: begin
        if (i_SPI_RX_DV) begin
          rx_byte_d = i_SPI_RX_Byte;
          a_rx_dv_d = grant_a_q;
          b_rx_dv_d = grant_b_q;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - CNT_W'(1);
          end
          if (remaining_q <= CNT_W'(1)) begin
            timer_d = HoldInit;
            state_d = StHold;
          end else begin
            state_d = StSend;
          end
        end
      end

      // Release waits for the timer to sit at zero, so CS_n stays low one clock
      // beyond the hold count after the cycle that entered this state.
      StHold: begin
        if (timer_q == 8'd0) begin
          cs_n_d    = 1'b1;
          grant_a_d = 1'b0;
          grant_b_d = 1'b0;
          a_done_d  = grant_a_q;
          b_done_d  = grant_b_q;
          timer_d   = IdleInit;
          state_d   = StGap;
        end else begin
          timer_d = timer_dec;
        end
      end

      StGap: begin
        if (timer_last) begin
          timer_d = 8'd0;
          state_d = StIdle;
        end else begin
          timer_d = timer_dec;
        end
      end

      default: begin
        state_d   = StIdle;
        cs_n_d    = 1'b1;
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
        timer_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= StIdle;
      timer_q     <= 8'd0;
      remaining_q <= '0;
      rr_b_q      <= 1'b0;
      grant_a_q   <= 1'b0;
      grant_b_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= 8'd0;
      rx_byte_q   <= 8'd0;
      a_taken_q   <= 1'b0;
      b_taken_q   <= 1'b0;
      a_rx_dv_q   <= 1'b0;
      b_rx_dv_q   <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      rr_b_q      <= rr_b_d;
      grant_a_q   <= grant_a_d;
      grant_b_q   <= grant_b_d;
      cs_n_q      <= cs_n_d;
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      rx_byte_q   <= rx_byte_d;
      a_taken_q   <= a_taken_d;
      b_taken_q   <= b_taken_d;
      a_rx_dv_q   <= a_rx_dv_d;
      b_rx_dv_q   <= b_rx_dv_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
    end
  end

  assign o_A_Grant     = grant_a_q;
  assign o_A_TX_Taken  = a_taken_q;
  assign o_A_RX_DV     = a_rx_dv_q;
  assign o_A_Done      = a_done_q;
  assign o_B_Grant     = grant_b_q;
  assign o_B_TX_Taken  = b_taken_q;
  assign o_B_RX_DV     = b_rx_dv_q;
  assign o_B_Done      = b_done_q;
  assign o_RX_Byte     = rx_byte_q;
  assign o_SPI_TX_Byte = tx_byte_q;
  assign o_SPI_TX_DV   = tx_dv_q;
  assign o_SPI_CS_n    = cs_n_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: behavioural SPI byte engine that echoes inverted
// bytes, an event monitor on the falling edge, and a linear sequence of checked steps.
module tb_spi_txn_arbiter;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_A_Req = 1'b0;
  logic [3:0] i_A_Count = 4'd0;
  logic [7:0] i_A_TX_Byte;
  logic       i_B_Req = 1'b0;
  logic [3:0] i_B_Count = 4'd0;
  logic [7:0] i_B_TX_Byte;
  logic       o_A_Grant, o_A_TX_Taken, o_A_RX_DV, o_A_Done;
  logic       o_B_Grant, o_B_TX_Taken, o_B_RX_DV, o_B_Done;
  logic [7:0] o_RX_Byte, o_SPI_TX_Byte;
  logic       o_SPI_TX_DV, o_SPI_CS_n;
  logic       i_SPI_TX_Ready;
  logic       i_SPI_RX_DV = 1'b0;
  logic [7:0] i_SPI_RX_Byte = 8'd0;

  spi_txn_arbiter #(
    .CS_SETUP_CLKS(4),
    .CS_HOLD_CLKS (4),
    .CS_IDLE_CLKS (8),
    .CNT_W        (4)
  ) u_dut (
    .i_Clk         (i_Clk),
    .i_Rst_L       (i_Rst_L),
    .i_A_Req       (i_A_Req),
    .i_A_Count     (i_A_Count),
    .i_A_TX_Byte   (i_A_TX_Byte),
    .o_A_Grant     (o_A_Grant),
    .o_A_TX_Taken  (o_A_TX_Taken),
    .o_A_RX_DV     (o_A_RX_DV),
    .o_A_Done      (o_A_Done),
    .i_B_Req       (i_B_Req),
    .i_B_Count     (i_B_Count),
    .i_B_TX_Byte   (i_B_TX_Byte),
    .o_B_Grant     (o_B_Grant),
    .o_B_TX_Taken  (o_B_TX_Taken),
    .o_B_RX_DV     (o_B_RX_DV),
    .o_B_Done      (o_B_Done),
    .o_RX_Byte     (o_RX_Byte),
    .o_SPI_TX_Byte (o_SPI_TX_Byte),
    .o_SPI_TX_DV   (o_SPI_TX_DV),
    .i_SPI_TX_Ready(i_SPI_TX_Ready),
    .i_SPI_RX_DV   (i_SPI_RX_DV),
    .i_SPI_RX_Byte (i_SPI_RX_Byte),
    .o_SPI_CS_n    (o_SPI_CS_n)
  );

  always #5 i_Clk = ~i_Clk;

  // Requester byte sources advance on each Taken pulse.
  logic [7:0] a_bytes [8];
  logic [7:0] b_bytes [8];
  int         a_base = 0, b_base = 0;
  int         a_tk_cnt = 0, b_tk_cnt = 0;
  assign i_A_TX_Byte = a_bytes[3'(a_tk_cnt - a_base)];
  assign i_B_TX_Byte = b_bytes[3'(b_tk_cnt - b_base)];

  // SPI engine model: 3 clocks per byte, echoes the inverted byte.
  logic       mdl_ready = 1'b1;
  logic       hold_ready_low = 1'b0;
  int         mdl_busy = 0;
  logic [7:0] mdl_byte = 8'd0;
  assign i_SPI_TX_Ready = mdl_ready & ~hold_ready_low;

  initial forever begin
    @(posedge i_Clk);
    #1;
    if (i_SPI_RX_DV) begin
      i_SPI_RX_DV = 1'b0;
      mdl_ready   = 1'b1;
    end
    if (mdl_busy > 0) begin
      mdl_busy = mdl_busy - 1;
      if (mdl_busy == 0) begin
        i_SPI_RX_DV   = 1'b1;
        i_SPI_RX_Byte = ~mdl_byte;
      end
    end
    if (o_SPI_TX_DV) begin
      mdl_byte  = o_SPI_TX_Byte;
      mdl_ready = 1'b0;
      mdl_busy  = 3;
    end
  end

  // Monitor, sampled on the falling edge.
  int         tx_cnt = 0, rx_total = 0, a_rx_cnt = 0, b_rx_cnt = 0;
  int         a_done_cnt = 0, b_done_cnt = 0, grant_total = 0, cs_fall_cnt = 0;
  int         cs_low_run = 0, cs_high_run = 0, last_low_len = 0, last_high_len = 0;
  int         first_tx_gap = 0, xerr = 0;
  bit         first_pending = 1'b0, prev_cs = 1'b1, prev_ga = 1'b0, prev_gb = 1'b0;
  logic [7:0] tx_log [64];
  logic [7:0] rx_log [64];
  bit         grant_log [16];

  initial forever begin
    @(negedge i_Clk);
    if (!o_SPI_CS_n) begin
      if (prev_cs) begin
        cs_fall_cnt++;
        last_high_len = cs_high_run;
        cs_low_run    = 0;
        first_pending = 1'b1;
      end
      cs_low_run++;
    end else begin
      if (!prev_cs) begin
        last_low_len = cs_low_run;
        cs_high_run  = 0;
      end
      cs_high_run++;
    end
    prev_cs = o_SPI_CS_n;
    if (o_SPI_TX_DV) begin
      tx_log[6'(tx_cnt)] = o_SPI_TX_Byte;
      tx_cnt++;
      if (first_pending) begin
        first_tx_gap  = cs_low_run;
        first_pending = 1'b0;
      end
    end
    if (o_A_RX_DV || o_B_RX_DV) begin
      rx_log[6'(rx_total)] = o_RX_Byte;
      rx_total++;
    end
    if (o_A_RX_DV) a_rx_cnt++;
    if (o_B_RX_DV) b_rx_cnt++;
    if (o_A_TX_Taken) a_tk_cnt++;
    if (o_B_TX_Taken) b_tk_cnt++;
    if (o_A_Done) a_done_cnt++;
    if (o_B_Done) b_done_cnt++;
    if (o_A_Grant && !prev_ga) begin
      grant_log[4'(grant_total)] = 1'b0;
      grant_total++;
    end
    if (o_B_Grant && !prev_gb) begin
      grant_log[4'(grant_total)] = 1'b1;
      grant_total++;
    end
    if (o_A_Grant && o_B_Grant) xerr++;
    if (!o_A_Grant && (o_A_TX_Taken || o_A_RX_DV)) xerr++;
    if (!o_B_Grant && (o_B_TX_Taken || o_B_RX_DV)) xerr++;
    prev_ga = o_A_Grant;
    prev_gb = o_B_Grant;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge i_Clk);
    #1;
  endtask

  int s_tx, s_rx, s_arx, s_brx, s_atk, s_btk, s_ad, s_bd, s_g, s_f;

  task automatic snap();
    s_tx  = tx_cnt;     s_rx  = rx_total;   s_arx = a_rx_cnt;  s_brx = b_rx_cnt;
    s_atk = a_tk_cnt;   s_btk = b_tk_cnt;   s_ad  = a_done_cnt; s_bd = b_done_cnt;
    s_g   = grant_total; s_f  = cs_fall_cnt;
  endtask

  task automatic do_reset();
    i_Rst_L = 1'b0;
    tick();
    i_Rst_L = 1'b1;
    tick();
  endtask

  // Raise one request, drop it the cycle after grant, wait for Done and the idle gap.
  task automatic run_txn(input bit is_b, input logic [3:0] cnt);
    int g0, d0;
    bit got;
    g0 = grant_total;
    d0 = a_done_cnt + b_done_cnt;
    if (is_b) begin
      i_B_Count = cnt;
      i_B_Req   = 1'b1;
    end else begin
      i_A_Count = cnt;
      i_A_Req   = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = (grant_total > g0);
    end
    i_A_Req = 1'b0;
    i_B_Req = 1'b0;
    chk("grant_seen", 32'(got), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      got = (a_done_cnt + b_done_cnt > d0);
    end
    chk("done_seen", 32'(got), 32'd1);
    repeat (12) tick();
  endtask

  initial begin
    bit         got, hl_got;
    int         hl;
    logic [2:0] order;

    for (int i = 0; i < 8; i++) begin
      a_bytes[i] = 8'h00;
      b_bytes[i] = 8'h00;
    end

    // Reset state
    repeat (3) tick();
    chk("rst_cs_n", 32'(o_SPI_CS_n), 32'd1);
    chk("rst_outputs", 32'({o_A_Grant, o_B_Grant, o_A_TX_Taken, o_B_TX_Taken, o_A_RX_DV,
                            o_B_RX_DV, o_A_Done, o_B_Done, o_SPI_TX_DV, o_SPI_TX_Byte,
                            o_RX_Byte}), 32'd0);
    i_Rst_L = 1'b1;
    tick();

    // A: three bytes, inverted echo
    a_bytes[0] = 8'h61; a_bytes[1] = 8'h62; a_bytes[2] = 8'h63;
    a_base = a_tk_cnt;
    snap();
    run_txn(1'b0, 4'd3);
    chk("t1_cs_falls", 32'(cs_fall_cnt - s_f), 32'd1);
    chk("t1_tx_count", 32'(tx_cnt - s_tx), 32'd3);
    chk("t1_tx_bytes", 32'({tx_log[6'(s_tx)], tx_log[6'(s_tx + 1)], tx_log[6'(s_tx + 2)]}),
        32'h616263);
    chk("t1_a_rx_count", 32'(a_rx_cnt - s_arx), 32'd3);
    chk("t1_rx_bytes", 32'({rx_log[6'(s_rx)], rx_log[6'(s_rx + 1)], rx_log[6'(s_rx + 2)]}),
        32'h9e9d9c);
    chk("t1_a_done", 32'(a_done_cnt - s_ad), 32'd1);
    chk("t1_b_quiet", 32'((b_rx_cnt - s_brx) + (b_tk_cnt - s_btk) + (b_done_cnt - s_bd)),
        32'd0);
    chk("t1_cs_low_len", 32'(last_low_len), 32'd24);
    chk("t1_setup_gap", 32'(first_tx_gap), 32'd6);

    // Simultaneous requests after reset: A, then B, then A
    do_reset();
    snap();
    a_bytes[0] = 8'h31; a_base = a_tk_cnt;
    b_bytes[0] = 8'h42; b_base = b_tk_cnt;
    i_A_Count = 4'd1; i_B_Count = 4'd1;
    i_A_Req = 1'b1; i_B_Req = 1'b1;
    got = 1'b0; hl_got = 1'b0; hl = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      if (grant_total >= s_g + 2 && !hl_got) begin
        hl     = last_high_len;
        hl_got = 1'b1;
      end
      got = (grant_total >= s_g + 3);
    end
    i_A_Req = 1'b0; i_B_Req = 1'b0;
    chk("t2_three_grants", 32'(got), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      got = (a_done_cnt + b_done_cnt >= s_ad + s_bd + 3);
    end
    chk("t2_three_dones", 32'(got), 32'd1);
    repeat (12) tick();
    order = {grant_log[4'(s_g)], grant_log[4'(s_g + 1)], grant_log[4'(s_g + 2)]};
    chk("t2_grant_order", 32'(order), 32'b010);
    chk("t2_cs_high_gap", 32'(hl), 32'd9);
    chk("t2_b_rx_count", 32'(b_rx_cnt - s_brx), 32'd1);

    // Zero-byte transaction
    snap();
    run_txn(1'b0, 4'd0);
    chk("t3_cs_low_len", 32'(last_low_len), 32'd9);
    chk("t3_no_tx", 32'(tx_cnt - s_tx), 32'd0);
    chk("t3_a_done", 32'(a_done_cnt - s_ad), 32'd1);

    // TX_Ready held low while in SEND
    hold_ready_low = 1'b1;
    a_bytes[0] = 8'h4c; a_base = a_tk_cnt;
    snap();
    i_A_Count = 4'd1;
    i_A_Req   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      got = (grant_total > s_g);
    end
    i_A_Req = 1'b0;
    chk("t4_grant_seen", 32'(got), 32'd1);
    repeat (24) tick();
    chk("t4_no_tx_dv", 32'(tx_cnt - s_tx), 32'd0);
    chk("t4_no_taken", 32'(a_tk_cnt - s_atk), 32'd0);
    chk("t4_cs_low", 32'(o_SPI_CS_n), 32'd0);
    hold_ready_low = 1'b0;
    chk("t4_dv_before", 32'(o_SPI_TX_DV), 32'd0);
    tick();
    chk("t4_dv_after", 32'(o_SPI_TX_DV), 32'd1);
    chk("t4_tx_byte", 32'(o_SPI_TX_Byte), 32'h4c);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = (a_done_cnt > s_ad);
    end
    repeat (12) tick();
    chk("t4_done", 32'(got), 32'd1);
    chk("t4_single_cs", 32'(cs_fall_cnt - s_f), 32'd1);
    chk("t4_rx_byte", 32'(o_RX_Byte), 32'hb3);

    // Asynchronous reset in the middle of a B transaction
    for (int i = 0; i < 5; i++) b_bytes[i] = 8'(8'h11 + i);
    b_base = b_tk_cnt;
    snap();
    i_B_Count = 4'd5;
    i_B_Req   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = (tx_cnt >= s_tx + 2);
    end
    chk("t5_second_byte", 32'(got), 32'd1);
    tick();
    #2;
    i_Rst_L = 1'b0;
    i_B_Req = 1'b0;
    #1;
    chk("t5_rst_cs_n", 32'(o_SPI_CS_n), 32'd1);
    chk("t5_rst_outs", 32'({o_A_Grant, o_B_Grant, o_SPI_TX_DV, o_A_RX_DV, o_B_RX_DV,
                            o_A_TX_Taken, o_B_TX_Taken, o_A_Done, o_B_Done}), 32'd0);
    tick();
    i_Rst_L = 1'b1;
    snap();
    repeat (10) tick();
    chk("t5_stale_rx_ignored", 32'(rx_total - s_rx), 32'd0);
    chk("t5_rx_byte_cleared", 32'(o_RX_Byte), 32'd0);
    a_bytes[0] = 8'h5a; a_base = a_tk_cnt;
    snap();
    run_txn(1'b0, 4'd1);
    chk("t5_a_rx_after", 32'(a_rx_cnt - s_arx), 32'd1);
    chk("t5_a_rx_byte", 32'(o_RX_Byte), 32'ha5);

    // A drops Req right after grant; both bytes still go out
    a_bytes[0] = 8'h71; a_bytes[1] = 8'h72; a_base = a_tk_cnt;
    snap();
    run_txn(1'b0, 4'd2);
    chk("t6_one_grant", 32'(grant_total - s_g), 32'd1);
    chk("t6_tx_count", 32'(tx_cnt - s_tx), 32'd2);
    chk("t6_tx_bytes", 32'({tx_log[6'(s_tx)], tx_log[6'(s_tx + 1)]}), 32'h7172);
    chk("t6_a_done", 32'(a_done_cnt - s_ad), 32'd1);

    chk("exclusivity", 32'(xerr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one SPI_Master byte engine between two requesters, A and B, and owns the chip-select line.
- Each grant runs one multi-byte transaction under a single CS assertion.
- Enforces CS setup, CS hold and inter-transaction idle timing.
- Sits between the application logic (display/character generators, sensor pollers) and the SPI_Master TX/RX byte interface.

Parameters:
- CS_SETUP_CLKS, 4: clocks from CS_n falling to the first TX_DV; legal range 1..255.
- CS_HOLD_CLKS, 4: clocks from the last RX_DV to CS_n rising; legal range 1..255.
- CS_IDLE_CLKS, 8: minimum clocks CS_n stays high between transactions; legal range 1..255.
- CNT_W, 4: width of the byte-count request field.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous, active-low reset
- i_A_Req  in  1  requester A wants a transaction; level, held until o_A_Grant
- i_A_Count  in  CNT_W  number of bytes for A; sampled at grant
- i_A_TX_Byte  in  8  next byte from A; sampled when o_A_TX_Taken=1
- o_A_Grant  out  1  high for the whole A transaction, from grant to o_A_Done
- o_A_TX_Taken  out  1  1-clk pulse: A's byte consumed; A presents the next byte from the following cycle
- o_A_RX_DV  out  1  1-clk pulse: o_RX_Byte is valid for A
- o_A_Done  out  1  1-clk pulse at CS_n release for an A transaction
- i_B_Req, i_B_Count, i_B_TX_Byte, o_B_Grant, o_B_TX_Taken, o_B_RX_DV, o_B_Done: identical for B
- o_RX_Byte  out  8  received byte, shared; registered copy of i_SPI_RX_Byte
- o_SPI_TX_Byte  out  8  to SPI_Master i_TX_Byte
- o_SPI_TX_DV  out  1  to SPI_Master i_TX_DV
- i_SPI_TX_Ready  in  1  from SPI_Master o_TX_Ready
- i_SPI_RX_DV  in  1  from SPI_Master o_RX_DV
- i_SPI_RX_Byte  in  8  from SPI_Master o_RX_Byte
- o_SPI_CS_n  out  1  chip select, active low

Behaviour:
- Reset (async, i_Rst_L=0), effective immediately including mid-transaction:
  - o_SPI_CS_n=1; all other outputs 0; o_RX_Byte=0.
  - FSM=IDLE; round-robin pointer favours A.
  - The SPI_Master in-flight byte is abandoned; its later RX_DV is ignored because the FSM is IDLE.
- States: IDLE, SETUP, SEND, WAIT_RX, HOLD, GAP. All outputs are registered.
- IDLE:
  - If exactly one Req is high, grant it. If both are high, grant the requester not served last (A first after reset).
  - On the grant edge: Grant=1, CS_n=0, remaining=Count latched, timer=CS_SETUP_CLKS, pointer updated; go to SETUP.
- SETUP:
  - Timer decrements each clock. At zero, go to SEND if remaining≠0, else to HOLD.
  - A Count of 0 gives a CS pulse with no bytes, then Done.
- SEND:
  - Wait for i_SPI_TX_Ready=1. In that cycle, register o_SPI_TX_Byte=granted TX_Byte, and pulse o_SPI_TX_DV and TX_Taken for 1 clk in the next cycle; go to WAIT_RX.
  - TX_DV is never asserted while Ready=0.
- WAIT_RX:
  - On i_SPI_RX_DV, register o_RX_Byte and pulse the granted RX_DV for 1 clk; remaining--.
  - If remaining reaches 0, go to HOLD with timer=CS_HOLD_CLKS; else go to SEND.
  - TX_Ready edges in this state are ignored.
- HOLD:
  - Timer decrements. At zero: CS_n=1, Grant=0, Done pulse for 1 clk, timer=CS_IDLE_CLKS; go to GAP.
- GAP:
  - Timer decrements; at zero go to IDLE. Requests are not granted during GAP.
- Request rules:
  - Dropping Req after grant does not abort; the transaction runs to completion.
  - Req held after Done is a new request. Round-robin makes the other side win if both are pending.
- Exclusivity:
  - At most one Grant is high at any time.
  - The non-granted requester's Taken/RX_DV/Done stay 0.
  - o_RX_Byte holds its last value between pulses.
- Counts:
  - remaining is CNT_W bits; maximum transaction is 2^CNT_W−1 bytes. There is no wrap, because decrement only occurs while remaining≠0.
- Timing guarantees:
  - CS_n low for ≥ CS_SETUP_CLKS before the first TX_DV.
  - CS_n low for ≥ CS_HOLD_CLKS after the last RX_DV.
  - CS_n high for ≥ CS_IDLE_CLKS+1 between transactions.

Test Plan:
- A requests Count=3, bytes 0x61,0x62,0x63; SPI model echoes inverted bytes → CS_n low once; 3 TX_DV carrying 0x61,0x62,0x63 in order; o_RX_Byte=0x9E,0x9D,0x9C with 3 A_RX_DV pulses; one A_Done; B outputs all 0.
- A and B both request in the same cycle after reset, Count=1 each, both held → A granted first, then after ≥9 clks of CS_n high B is granted; with both held again, A wins next.
- A requests Count=0 → CS_n low for CS_SETUP_CLKS+CS_HOLD_CLKS+1 clks; no TX_DV; A_Done pulses once.
- Hold i_SPI_TX_Ready=0 for 20 clks in SEND → no TX_DV and no Taken; TX_DV issues 1 clk after Ready rises; CS_n stays low throughout.
- Assert i_Rst_L=0 during WAIT_RX of a 5-byte B transaction → CS_n=1 and Grant/DV outputs=0 asynchronously; after release, a stale RX_DV produces no RX_DV pulse; next A request is served normally.
- A drops Req one cycle after grant with Count=2 → both bytes still transferred; Done pulses; no second grant.
